// File: rtl/arm_rf_pkg.sv
// Shared types and default sizes for the multi-port ARM register file.
// Holds the clear-sequencer state encoding and default geometry.
package arm_rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rfState_t;

  localparam int RF_W       = 32;
  localparam int RF_DEPTH   = 16;
  localparam int RF_AW      = 4;
  localparam int RF_NRD     = 2;
  localparam int RF_PC_STEP = 4;

endpackage

// File: rtl/rf_clear_seq.sv
// Sweep-clear sequencer: IDLE/SWEEP FSM, clear counter, busy, write reject.
// Ports: CLK, CLR (async, active-high), RW, SCLR, addr_wr in;
//   busy, wr_reject, wrAccept, bypassEn, sweepEn, idle, cnt out.
module rf_clear_seq
  import arm_rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          RW,
  input  logic          SCLR,
  input  logic [AW-1:0] addr_wr,
  output logic          busy,
  output logic          wr_reject,
  output logic          wrAccept,
  output logic          bypassEn,
  output logic          sweepEn,
  output logic          idle,
  output logic [AW-1:0] cnt
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rfState_t      state;
  rfState_t      nextState;
  logic [AW-1:0] cntNext;
  logic          rejNext;
  logic          wrInRange;

  assign idle      = (state == RF_IDLE);
  assign sweepEn   = (state == RF_SWEEP);
  assign wrInRange = {1'b0, addr_wr} < (AW + 1)'(DEPTH);
  // SCLR has priority over a same-cycle write.
  assign bypassEn  = idle & RW & ~SCLR;
  assign wrAccept  = bypassEn & wrInRange;

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    rejNext   = 1'b0;
    unique case (state)
      RF_IDLE: begin
        rejNext = RW & SCLR;
        if (SCLR) begin
          nextState = RF_SWEEP;
          cntNext   = '0;
        end
      end
      RF_SWEEP: begin
        rejNext = RW;
        if (cnt == LAST) begin
          nextState = RF_IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + AW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= RF_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      state     <= nextState;
      cnt       <= cntNext;
      busy      <= (nextState == RF_SWEEP);
      wr_reject <= rejNext;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with write bypass and sweep clear.
// Ports: CLK, CLR, addr_rd/data_rd (NRD ports), addr_wr, data_wr, RW,
//   SCLR in; data_rd, busy, wr_reject out. RF_PC_AUTOINC_EN enables PC step.
module register_file_mp
  import arm_rf_pkg::*;
#(
  parameter int W       = RF_W,
  parameter int DEPTH   = RF_DEPTH,
  parameter int AW      = RF_AW,
  parameter int NRD     = RF_NRD,
  parameter int PC_STEP = RF_PC_STEP
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [NRD*AW-1:0] addr_rd,
  output logic [NRD*W-1:0]  data_rd,
  input  logic [AW-1:0]     addr_wr,
  input  logic [W-1:0]      data_wr,
  input  logic              RW,
  input  logic              SCLR,
  output logic              busy,
  output logic              wr_reject
);

`ifdef RF_PC_AUTOINC_EN
  localparam bit PC_AUTO = 1'b1;
`else
  localparam bit PC_AUTO = 1'b0;
`endif

  localparam logic [AW-1:0] PC_IDX = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic          wrAccept;
  logic          bypassEn;
  logic          sweepEn;
  logic          idle;
  logic [AW-1:0] cnt;
  logic          pcInc;

  rf_clear_seq #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) uSeq (
    .CLK      (CLK),
    .CLR      (CLR),
    .RW       (RW),
    .SCLR     (SCLR),
    .addr_wr  (addr_wr),
    .busy     (busy),
    .wr_reject(wr_reject),
    .wrAccept (wrAccept),
    .bypassEn (bypassEn),
    .sweepEn  (sweepEn),
    .idle     (idle),
    .cnt      (cnt)
  );

  // An accepted write to the PC slot wins over the increment.
  assign pcInc = PC_AUTO & idle &
                 ~(wrAccept & (addr_wr == PC_IDX));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sweepEn) begin
      mem[cnt] <= '0;
    end else begin
      if (wrAccept) begin
        mem[addr_wr] <= data_wr;
      end
      if (pcInc) begin
        mem[DEPTH-1] <= mem[DEPTH-1] + W'(PC_STEP);
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : gRd
    logic [AW-1:0] ra;
    logic [W-1:0]  rd;
    logic          inRange;

    assign ra      = addr_rd[k*AW +: AW];
    assign inRange = {1'b0, ra} < (AW + 1)'(DEPTH);

    always_comb begin
      rd = '0;
      if (!CLR && inRange) begin
        if (bypassEn && (ra == addr_wr)) begin
          rd = data_wr;
        end else begin
          rd = mem[ra];
        end
      end
    end

    assign data_rd[k*W +: W] = rd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: vector table plus
// hand sequences for reset, sweep, reject, mid-sweep CLR and PC step.
module tb_register_file_mp;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NRD   = 2;

  logic              CLK = 1'b0;
  logic              CLR;
  logic [NRD*AW-1:0] addr_rd;
  logic [NRD*W-1:0]  data_rd;
  logic [AW-1:0]     addr_wr;
  logic [W-1:0]      data_wr;
  logic              RW;
  logic              SCLR;
  logic              busy;
  logic              wr_reject;

  int compared   = 0;
  int mismatched = 0;

  register_file_mp dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .addr_rd  (addr_rd),
    .data_rd  (data_rd),
    .addr_wr  (addr_wr),
    .data_wr  (data_wr),
    .RW       (RW),
    .SCLR     (SCLR),
    .busy     (busy),
    .wr_reject(wr_reject)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    bit          rw;
    bit          sclr;
    int          aw;
    logic [31:0] dw;
    int          a0;
    int          a1;
    logic [31:0] e0;
    logic [31:0] e1;
    bit          eb;
    bit          er;
  } vec_t;

  vec_t vt[9];

  function automatic logic [W-1:0] rd0();
    return data_rd[W-1:0];
  endfunction

  function automatic logic [W-1:0] rd1();
    return data_rd[2*W-1:W];
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit rw, bit sclr, int aw,
                       logic [31:0] dw, int a0, int a1);
    RW      = rw;
    SCLR    = sclr;
    addr_wr = AW'(aw);
    data_wr = dw;
    addr_rd = {AW'(a1), AW'(a0)};
  endtask

  task automatic setRd(int a0, int a1);
    addr_rd = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitIdle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    chk("idle timeout", 32'(busy), 32'h0);
  endtask

  initial begin
    int cyc;

    CLR = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    CLR = 1'b0;
    tick();

    // Reset clears a preloaded register at once.
    drive(1, 0, 3, 32'hDEADBEEF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 3, 3);
    #1;
    chk("preload R3", rd0(), 32'hDEADBEEF);
    CLR = 1'b1;
    #1;
    chk("rst rd0", rd0(), 32'h0);
    chk("rst rd1", rd1(), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst rej", 32'(wr_reject), 32'h0);
    tick();
    CLR = 1'b0;
    tick();

    // rw sclr aw dw a0 a1 e0 e1 busy rej
    vt[0] = '{1, 0, 5, 32'h55, 5, 0, 32'h55, 32'h0, 0, 0};
    vt[1] = '{0, 0, 0, 32'h0, 5, 0, 32'h55, 32'h0, 0, 0};
    vt[2] = '{1, 0, 7, 32'h12345678, 5, 7,
              32'h55, 32'h12345678, 0, 0};
    vt[3] = '{0, 0, 0, 32'h0, 7, 5, 32'h12345678, 32'h55, 0, 0};
    vt[4] = '{1, 0, 3, 32'hAAAA, 3, 3, 32'hAAAA, 32'hAAAA, 0, 0};
    vt[5] = '{1, 0, 3, 32'hBBBB, 3, 5, 32'hBBBB, 32'h55, 0, 0};
    vt[6] = '{0, 0, 0, 32'h0, 3, 2, 32'hBBBB, 32'h0, 0, 0};
    vt[7] = '{1, 1, 2, 32'hCC, 2, 3, 32'h0, 32'hBBBB, 0, 0};
    vt[8] = '{0, 0, 0, 32'h0, 2, 3, 32'h0, 32'hBBBB, 1, 1};

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].rw, vt[i].sclr, vt[i].aw, vt[i].dw,
            vt[i].a0, vt[i].a1);
      #1;
      chk($sformatf("v%0d rd0", i), rd0(), vt[i].e0);
      chk($sformatf("v%0d rd1", i), rd1(), vt[i].e1);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].eb));
      chk($sformatf("v%0d rej", i), 32'(wr_reject),
          32'(vt[i].er));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    waitIdle(cyc);
    setRd(3, 5);
    chk("post sweep R3", rd0(), 32'h0);
    chk("post sweep R5", rd1(), 32'h0);
    setRd(7, 2);
    chk("post sweep R7", rd0(), 32'h0);
    chk("dropped R2", rd1(), 32'h0);

    // Full sweep: fill, then count busy cycles.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, i, 32'(i + 1), 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 9) begin
        for (int j = 0; j < 4; j++) begin
          setRd(2 * j, 2 * j + 1);
          chk($sformatf("mid R%0d", 2 * j), rd0(), 32'h0);
          chk($sformatf("mid R%0d", 2 * j + 1), rd1(), 32'h0);
        end
        setRd(8, 15);
        chk("mid R8", rd0(), 32'h9);
`ifndef RF_PC_AUTOINC_EN
        chk("mid R15", rd1(), 32'h10);
`endif
      end
      tick();
    end
    chk("sweep busy cycles", 32'(cyc), 32'd16);
    for (int j = 0; j < DEPTH / 2; j++) begin
      setRd(2 * j, 2 * j + 1);
      chk($sformatf("end R%0d", 2 * j), rd0(), 32'h0);
      chk($sformatf("end R%0d", 2 * j + 1), rd1(), 32'h0);
    end

    // Write during sweep after R2's slot is dropped.
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(1, 0, 2, 32'hAA, 2, 0);
    #1;
    chk("sweep no bypass", rd0(), 32'h0);
    chk("sweep rej pre", 32'(wr_reject), 32'h0);
    tick();
    drive(0, 0, 0, 0, 2, 0);
    #1;
    chk("sweep R2 kept", rd0(), 32'h0);
    chk("sweep rej", 32'(wr_reject), 32'h1);
    tick();
    chk("sweep rej drop", 32'(wr_reject), 32'h0);
    waitIdle(cyc);
    setRd(2, 0);
    chk("after sweep R2", rd0(), 32'h0);

    // CLR in the middle of a sweep.
    drive(1, 0, 9, 32'h99, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    drive(1, 0, 9, 32'h77, 9, 0);
    tick();
    drive(0, 0, 0, 0, 9, 0);
    #1;
    chk("pre clr R9", rd0(), 32'h99);
    chk("pre clr rej", 32'(wr_reject), 32'h1);
    CLR = 1'b1;
    #1;
    chk("clr busy", 32'(busy), 32'h0);
    chk("clr rej", 32'(wr_reject), 32'h0);
    chk("clr R9", rd0(), 32'h0);
    tick();
    CLR = 1'b0;
    drive(1, 0, 1, 32'h11, 1, 0);
    tick();
    drive(0, 1, 0, 0, 1, 0);
    #1;
    chk("post clr R1", rd0(), 32'h11);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    waitIdle(cyc);
    chk("restart sweep len", 32'(cyc), 32'd16);

`ifdef RF_PC_AUTOINC_EN
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    setRd(15, 0);
    chk("pc 0", rd0(), 32'h0);
    tick();
    chk("pc 4", rd0(), 32'h4);
    tick();
    chk("pc 8", rd0(), 32'h8);
    drive(1, 0, 15, 32'h100, 15, 0);
    #1;
    chk("pc bypass", rd0(), 32'h100);
    tick();
    drive(0, 0, 0, 0, 15, 0);
    #1;
    chk("pc write", rd0(), 32'h100);
    tick();
    chk("pc step", rd0(), 32'h104);
`else
    drive(1, 0, 15, 32'h100, 15, 0);
    #1;
    chk("r15 bypass", rd0(), 32'h100);
    tick();
    drive(0, 0, 0, 0, 15, 0);
    #1;
    chk("r15 write", rd0(), 32'h100);
    tick();
    chk("r15 hold", rd0(), 32'h100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
